pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register for the MIPS pipeline. It generalises the fixed 32-bit stage registers to any payload width. It replaces the raw stall/flush pair with a valid/ready handshake, backed by a 2-entry skid buffer so that no combinational path runs from downstream ready to upstream ready. It also adds a synchronous flush with optional data zeroing (NOP insertion) and a saturating stall-cycle counter for performance analysis. It sits between any two pipeline stages (IF/ID, ID/EX, ...).

Parameters:
WIDTH, 64, payload width in bits (e.g. Instruction + PCPlus4)
CLEAR_ON_FLUSH, 1, 1 = zero both data entries on flush/reset (all-zero = NOP); 0 = data holds, only valids cleared
STALL_CNT_W, 16, width of the stall counter

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  reset, synchronous, active-low
Flush  in  1  synchronous kill of stage contents
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept (registered)
in_data  in  WIDTH  upstream payload
out_valid  out  1  main entry holds valid payload
out_ready  in  1  downstream accepts
out_data  out  WIDTH  main entry payload
occupancy  out  2  number of valid entries, 0..2
stat_clr  in  1  clear stall counter
stall_count  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage is a main register (drives out_data/out_valid) and a skid register. There are 3 states: EMPTY (occ 0), HALF (main valid), FULL (main + skid valid).
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = ~skid_valid, driven from a flop. It is never a function of out_ready in the same cycle.
- EMPTY:
  - in_fire -> main <= in_data; go to HALF.
  - Otherwise stay in EMPTY.
- HALF:
  - in_fire & out_fire -> main <= in_data; stay in HALF.
  - in_fire only -> skid <= in_data; go to FULL.
  - out_fire only -> go to EMPTY.
  - Neither -> hold.
- FULL (in_ready=0):
  - out_fire -> main <= skid; go to HALF.
  - Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid when EMPTY/HALF. Throughput is 1/cycle with no bubbles while out_ready=1.
- Ordering: strictly FIFO. The skid entry is always older than any new input.
- Flush priority: Rst low > Flush > normal operation.
- Flush=1 at an edge:
  - Both valids -> 0; occupancy -> 0; in_ready -> 1 the next cycle.
  - Any in_data presented that cycle is discarded even if in_valid=1.
  - Both data registers -> 0 if CLEAR_ON_FLUSH=1; unchanged otherwise.
  - A downstream out_fire in the flush cycle still counts as a transfer for the consumer. The stage itself simply ends up empty.
- Reset (Rst=0 at an edge):
  - out_valid=0, skid valid=0, in_ready=1, occupancy=0, stall_count=0.
  - out_data=0 regardless of CLEAR_ON_FLUSH.
  - Reset mid-transfer drops all contents.
- Stall counter:
  - Increments when out_valid=1 & out_ready=0 at an edge.
  - Saturates at 2^STALL_CNT_W-1; no wrap.
  - stat_clr=1 -> 0 that edge, and clear beats increment.
  - Flush does not affect the counter.
- Data registers load only on the listed transfers, so there are no spurious enable glitches. Data is unknown-free after reset.

Test Plan:
- Reset, then stream in_data 1..8 with out_ready=1 -> out_data 1..8 on consecutive cycles starting one cycle after the first in_fire; occupancy stays 1; stall_count=0.
- Fill with A, B while out_ready=0 -> occupancy 2, in_ready=0 the cycle after B; C held upstream. Then raise out_ready -> A, B, C delivered in order with no loss or duplicate.
- Occupancy 2 with A, B, assert Flush with in_valid=1 carrying C -> next cycle out_valid=0, occupancy 0, in_ready=1, out_data=0 (CLEAR_ON_FLUSH=1); C never appears.
- STALL_CNT_W=3: hold out_valid=1 and out_ready=0 for 10 cycles -> stall_count saturates at 7. Pulse stat_clr together with the stall -> next value 0.
- Drive Rst=0 for one edge while FULL and mid-stall -> out_valid=0, occupancy 0, stall_count 0, in_ready 1. Operation resumes correctly with in_data 0x55.
- Random in_valid/out_ready at 50% for 10k cycles -> scoreboard shows in-order, lossless delivery, and in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready comes straight from a flop, so downstream ready never reaches upstream combinationally.
module pipe_stage_skid #(
    parameter int WIDTH          = 64,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [1:0]             occupancy,
    input  logic                   stat_clr,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] c);
        if (&c) return c;
        return c + CNT_ONE;
    endfunction

    state_t                   state_p0;
    state_t                   state_nxt;
    logic                     vld_p0;
    logic                     rdy_p0;
    logic [WIDTH-1:0]         data_p0;
    logic [WIDTH-1:0]         skid_data_p0;
    logic [STALL_CNT_W-1:0]   stall_cnt_p0;

    logic in_fire;
    logic out_fire;
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid;

    assign in_fire  = in_valid & rdy_p0;
    assign out_fire = vld_p0 & out_ready;

    always_comb begin
        state_nxt    = state_p0;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_p0)
            EMPTY: begin
                if (in_fire) begin
                    ld_main_in = 1'b1;
                    state_nxt  = HALF;
                end
            end
            HALF: begin
                if (in_fire && out_fire) begin
                    ld_main_in = 1'b1;
                end else if (in_fire) begin
                    ld_skid   = 1'b1;
                    state_nxt = FULL;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // Skid entry is always the older one, so it moves forward first.
                if (out_fire) begin
                    ld_main_skid = 1'b1;
                    state_nxt    = HALF;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (Flush) begin
            state_nxt    = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    // Stage register: state, registered handshake flags and both data entries
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_p0     <= EMPTY;
            vld_p0       <= 1'b0;
            rdy_p0       <= 1'b1;
            data_p0      <= '0;
            skid_data_p0 <= '0;
        end else begin
            state_p0 <= state_nxt;
            vld_p0   <= (state_nxt != EMPTY);
            rdy_p0   <= (state_nxt != FULL);
            if (Flush && (CLEAR_ON_FLUSH != 0)) begin
                data_p0      <= '0;
                skid_data_p0 <= '0;
            end else begin
                if (ld_main_in) begin
                    data_p0 <= in_data;
                end else if (ld_main_skid) begin
                    data_p0 <= skid_data_p0;
                end
                if (ld_skid) begin
                    skid_data_p0 <= in_data;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stall_cnt_p0 <= '0;
        end else if (stat_clr) begin
            stall_cnt_p0 <= '0;
        end else if (vld_p0 && !out_ready) begin
            stall_cnt_p0 <= sat_inc(stall_cnt_p0);
        end
    end

    assign in_ready    = rdy_p0;
    assign out_valid   = vld_p0;
    assign out_data    = data_p0;
    assign occupancy   = state_p0;
    assign stall_count = stall_cnt_p0;

endmodule
